// File: rtl/mac_pkg.sv
// Shared constants for the MAC write-back path.
// FP16 fields, image element layout, saturation magnitude.
package mac_pkg;
  localparam int ELEMS    = 9;
  localparam int BIAS_IN  = 15;
  localparam int BIAS_OUT = 7;

  localparam int FP_SIGN   = 15;
  localparam int FP_EXP_HI = 14;
  localparam int FP_EXP_LO = 10;
  localparam int FP_MAN_HI = 9;
  localparam int FP_MAN_W  = 10;

  localparam int IMG_W     = 8;
  localparam int IMG_EXP_W = 4;
  localparam int IMG_MAN_W = 3;

  localparam logic [6:0] SAT_MAG = 7'h7F;
  localparam logic [4:0] EXP_MAX = 5'h1F;

  typedef logic [IMG_W-1:0] img8_t;
  typedef logic [ELEMS*IMG_W-1:0] word_t;
endpackage

// File: rtl/fp16_to_img8.sv
// FP16 to 1-4-3 image element conversion.
// Round-to-nearest-even, saturating, flush of small values.
module fp16_to_img8
  import mac_pkg::*;
#(
  parameter int BIAS_IN  = mac_pkg::BIAS_IN,
  parameter int BIAS_OUT = mac_pkg::BIAS_OUT
) (
  input  logic [15:0] fp_i,
  output img8_t       img_o,
  output logic        sat_o
);
  localparam logic [4:0] SHIFT = 5'(BIAS_IN - BIAS_OUT);

  logic                s;
  logic [4:0]          e;
  logic [FP_MAN_W-1:0] m;
  logic [2:0]          m3;
  logic                rnd;
  logic [3:0]          m4;
  logic [5:0]          e8;

  assign s   = fp_i[FP_SIGN];
  assign e   = fp_i[FP_EXP_HI:FP_EXP_LO];
  assign m   = fp_i[FP_MAN_HI:0];
  assign m3  = m[9:7];
  assign rnd = m[6] & ((|m[5:0]) | m3[0]);
  assign m4  = {1'b0, m3} + {3'b0, rnd};
  // Mantissa carry bumps the exponent; m4[2:0] is already zero then.
  assign e8  = {1'b0, e - SHIFT} + {5'b0, m4[3]};

  // Select special, flushed, saturated or ordinary encoding.
  always_comb begin
    img_o = '0;
    sat_o = 1'b0;
    if (e == EXP_MAX) begin
      sat_o = 1'b1;
      img_o = (m != '0) ? {1'b0, SAT_MAG} : {s, SAT_MAG};
    end else if (e <= SHIFT) begin
      img_o = '0;
    end else if (e8 >= 6'd16) begin
      sat_o = 1'b1;
      img_o = {s, SAT_MAG};
    end else begin
      img_o = {s, e8[3:0], m4[2:0]};
    end
  end
endmodule

// File: rtl/mac_result_packer.sv
// Requantizes FP16 MAC results and packs nine
// 8-bit elements per 72-bit image word.
module mac_result_packer
  import mac_pkg::*;
#(
  parameter int ELEMS    = mac_pkg::ELEMS,
  parameter int BIAS_IN  = mac_pkg::BIAS_IN,
  parameter int BIAS_OUT = mac_pkg::BIAS_OUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [71:0] out_data,
  output logic [3:0]  out_count,
  output logic        sat_flag
);
  img8_t       conv;
  logic        conv_sat;

  logic        c_valid_q, c_valid_d;
  img8_t       c_data_q, c_data_d;
  logic        c_last_q, c_last_d;
  logic        sat_q, sat_d;
  logic [71:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ov_q, ov_d;
  logic [71:0] od_q, od_d;
  logic [3:0]  oc_q, oc_d;

  logic        out_free;
  logic        c_done;
  logic        c_advance;
  logic        in_fire;
  logic [71:0] acc_ins;

  fp16_to_img8 #(
    .BIAS_IN (BIAS_IN),
    .BIAS_OUT(BIAS_OUT)
  ) u_conv (
    .fp_i (in_data),
    .img_o(conv),
    .sat_o(conv_sat)
  );

  assign out_free  = !ov_q || out_ready;
  assign c_done    = (cnt_q == 4'(ELEMS - 1)) || c_last_q;
  assign c_advance = c_valid_q && (!c_done || out_free);
  assign in_ready  = !c_valid_q || c_advance;
  assign in_fire   = in_valid && in_ready;
  assign acc_ins   = acc_q | ({c_data_q, 64'h0} >> {cnt_q, 3'b000});

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_count = oc_q;
  assign sat_flag  = sat_q;

  // Next state for stage C, pack accumulator and output word.
  always_comb begin
    c_valid_d = c_valid_q;
    c_data_d  = c_data_q;
    c_last_d  = c_last_q;
    sat_d     = sat_q | (in_fire & conv_sat);
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ov_d      = ov_q && !out_ready;
    od_d      = od_q;
    oc_d      = oc_q;
    if (in_fire) begin
      c_valid_d = 1'b1;
      c_data_d  = conv;
      c_last_d  = in_last;
    end else if (c_advance) begin
      c_valid_d = 1'b0;
    end
    if (c_advance) begin
      if (c_done) begin
        ov_d  = 1'b1;
        od_d  = acc_ins;
        oc_d  = cnt_q + 4'd1;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = acc_ins;
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid_q <= 1'b0;
      c_data_q  <= '0;
      c_last_q  <= 1'b0;
      sat_q     <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ov_q      <= 1'b0;
      od_q      <= '0;
      oc_q      <= '0;
    end else begin
      c_valid_q <= c_valid_d;
      c_data_q  <= c_data_d;
      c_last_q  <= c_last_d;
      sat_q     <= sat_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ov_q      <= ov_d;
      od_q      <= od_d;
      oc_q      <= oc_d;
    end
  end
endmodule

// File: tb/tb_mac_result_packer.sv
// Scoreboard bench for mac_result_packer.
// Expected words built from an independent conversion model.
module tb_mac_result_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [71:0] out_data;
  logic [3:0]  out_count;
  logic        sat_flag;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  int pop_cyc = -10;
  int words  = 0;
  int b2b    = 0;
  int ir_low = 0;
  logic [71:0] last_data;
  logic [3:0]  last_cnt;
  logic        stall_prev = 1'b0;
  logic [71:0] stall_val;

  logic [75:0] sb[$];
  logic [71:0] mdl_word = '0;
  int          mcnt = 0;

  mac_result_packer dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count),
    .sat_flag (sat_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [79:0] got,
                     input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_conv(input logic [15:0] x);
    int e;
    int sig;
    int q;
    int r;
    int ex;
    e   = int'(x[14:10]);
    sig = int'({1'b1, x[9:0]});
    if (e == 31) return (x[9:0] != 0) ? 8'h7F : {x[15], 7'h7F};
    if (e <= 8) return 8'h00;
    q = sig >> 7;
    r = sig & 127;
    if (r > 64 || (r == 64 && q[0])) q++;
    ex = e - 8;
    if (q == 16) begin
      q = 8;
      ex++;
    end
    if (ex >= 16) return {x[15], 7'h7F};
    return {x[15], ex[3:0], q[2:0]};
  endfunction

  function automatic logic [15:0] i2h(input int n);
    int p;
    int mm;
    p = 0;
    for (int i = 0; i < 5; i++) if (((n >> i) & 1) == 1) p = i;
    mm = (n << (10 - p)) & 'h3FF;
    return {1'b0, 5'(p + 15), mm[9:0]};
  endfunction

  task automatic model_push(input logic [15:0] d, input logic l);
    logic [71:0] b;
    b = {m_conv(d), 64'h0};
    mdl_word = mdl_word | (b >> (8 * mcnt));
    mcnt++;
    if (mcnt == 9 || l) begin
      sb.push_back({4'(mcnt), mdl_word});
      mdl_word = '0;
      mcnt = 0;
    end
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && w < 300) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("in_timeout", 80'd0, 80'd1);
    end else begin
      acc_cyc = cyc;
      model_push(d, l);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 500) begin
      w++;
      @(posedge clk);
    end
    chk("drain_left", 80'(sb.size()), 80'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pop and compare on each word transfer.
  always @(negedge clk) begin
    logic [75:0] e;
    if (!rst && in_valid && !in_ready) ir_low++;
    if (!rst && out_valid && !out_ready) begin
      if (stall_prev) chk("stall_stable", 80'(out_data), 80'(stall_val));
      stall_val  = out_data;
      stall_prev = 1'b1;
    end else begin
      stall_prev = 1'b0;
    end
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", 80'(out_data), 80'h0);
      end else begin
        e = sb.pop_front();
        chk("word_data", 80'(out_data), 80'(e[71:0]));
        chk("word_count", 80'(out_count), 80'(e[75:72]));
      end
      if (cyc == pop_cyc + 1) b2b++;
      pop_cyc   = cyc;
      last_data = out_data;
      last_cnt  = out_count;
      words++;
    end
  end

  logic [15:0] rnd_set[5] = '{16'h3C40, 16'h3CC0, 16'hC000, 16'h5FC0, 16'h2000};
  logic [15:0] spc_set[4] = '{16'h7BFF, 16'hFC00, 16'h7E00, 16'h0001};

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 80'(out_valid), 80'd0);
    chk("rst_out_data", 80'(out_data), 80'd0);
    chk("rst_out_count", 80'(out_count), 80'd0);
    chk("rst_sat", 80'(sat_flag), 80'd0);
    chk("rst_in_ready", 80'(in_ready), 80'd1);
    rst = 1'b0;
    out_ready = 1'b1;

    for (int i = 0; i < 9; i++) send(16'h3C00, 1'b0);
    wait_drain();
    chk("ones_data", 80'(last_data), 80'h383838383838383838);
    chk("ones_count", 80'(last_cnt), 80'd9);
    chk("ones_latency", 80'(pop_cyc - acc_cyc), 80'd2);
    chk("ones_sat", 80'(sat_flag), 80'd0);

    for (int i = 0; i < 5; i++) send(rnd_set[i], i == 4);
    wait_drain();
    chk("rnd_data", 80'(last_data), 80'h383AC07F0000000000);
    chk("rnd_count", 80'(last_cnt), 80'd5);
    chk("rnd_sat", 80'(sat_flag), 80'd1);

    for (int i = 0; i < 4; i++) send(spc_set[i], i == 3);
    wait_drain();
    chk("spc_data", 80'(last_data), 80'h7FFF7F000000000000);
    chk("spc_count", 80'(last_cnt), 80'd4);

    words  = 0;
    b2b    = 0;
    ir_low = 0;
    fork
      begin
        out_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      begin
        for (int n = 1; n <= 27; n++) send(i2h(n), 1'b0);
      end
    join
    wait_drain();
    chk("bp_words", 80'(words), 80'd3);
    chk("bp_in_ready_low", 80'(ir_low > 0), 80'd1);
    chk("bp_drain_load", 80'(b2b > 0), 80'd1);

    words  = 0;
    ir_low = 0;
    for (int i = 0; i < 90; i++) send(16'($urandom), 1'b0);
    wait_drain();
    chk("b2b_words", 80'(words), 80'd10);
    chk("b2b_no_stall", 80'(ir_low), 80'd0);

    for (int i = 0; i < 5; i++) send(16'h3C00, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", 80'(out_valid), 80'd0);
    chk("mid_rst_in_ready", 80'(in_ready), 80'd1);
    mdl_word = '0;
    mcnt = 0;
    rst = 1'b0;
    words = 0;
    for (int i = 0; i < 9; i++) send(16'h4000, 1'b0);
    wait_drain();
    chk("post_rst_words", 80'(words), 80'd1);
    chk("post_rst_data", 80'(last_data), 80'h404040404040404040);
    chk("post_rst_count", 80'(last_cnt), 80'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end
endmodule
